// File: rtl/dmem_lsu.sv
// Load/store initiator between the execute stage and a word-addressed,
// single-port data memory. Sub-word stores are done as read-modify-write.
//
// state  | meaning
// IDLE   | ready for a request
// LOAD   | read the word, extract and extend the lane into resp_rdata
// STWR   | full-word write
// RMWRD  | read the word and merge the store lane into mem_din
// RMWWR  | write the merged word back
// RESP   | hold the response until resp_ready
module dmem_lsu #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_we,
    input  logic [31:0] mem_dout
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STWR, S_RMWRD, S_RMWWR, S_RESP
    } state_t;

    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    state_t          state;
    state_t          state_nx;
    logic [AW+1:0]   addr_q;
    logic [2:0]      f3_q;
    logic [31:0]     wdata_q;
    logic [31:0]     merge_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic            accept;
    logic            req_err;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [31:0]     load_ext;
    logic [31:0]     merged;

    assign accept = req_valid && req_ready;

    // Request legality: funct3 code, natural alignment and word range.
    always_comb begin
        req_err = 1'b0;
        if (req_funct3[1:0] == 2'b11)
            req_err = 1'b1;
        if (req_we && req_funct3[2])
            req_err = 1'b1;
        if (!req_we && req_funct3 == 3'b110)
            req_err = 1'b1;
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            req_err = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        if (req_addr[31:2] >= DEPTH_W)
            req_err = 1'b1;
    end

    // Lane extraction with sign/zero extension, and lane merge for RMW.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_b = mem_dout[7:0];
            2'd1:    lane_b = mem_dout[15:8];
            2'd2:    lane_b = mem_dout[23:16];
            default: lane_b = mem_dout[31:24];
        endcase
        lane_h = addr_q[1] ? mem_dout[31:16] : mem_dout[15:0];
        case (f3_q[1:0])
            2'b00:   load_ext = {{24{lane_b[7] & ~f3_q[2]}}, lane_b};
            2'b01:   load_ext = {{16{lane_h[15] & ~f3_q[2]}}, lane_h};
            default: load_ext = mem_dout;
        endcase
        merged = mem_dout;
        if (f3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_nx = S_RESP;
                    else if (!req_we)
                        state_nx = S_LOAD;
                    else if (req_funct3[1:0] == 2'b10)
                        state_nx = S_STWR;
                    else
                        state_nx = S_RMWRD;
                end
            end
            S_LOAD:  state_nx = S_RESP;
            S_STWR:  state_nx = S_RESP;
            S_RMWRD: state_nx = S_RMWWR;
            S_RMWWR: state_nx = S_RESP;
            S_RESP:  if (resp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Request latch, load result and merged-word registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr[AW+1:0];
                f3_q    <= req_funct3;
                wdata_q <= req_wdata;
                err_q   <= req_err;
                rdata_q <= '0;
            end
            if (state == S_LOAD)
                rdata_q <= load_ext;
            if (state == S_RMWRD)
                merge_q <= merged;
        end
    end

    // Outputs; everything is forced quiet while rst is high so a reset
    // during a write state never reaches the memory.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_din    = '0;
        if (!rst) begin
            case (state)
                S_IDLE: req_ready = 1'b1;
                S_LOAD, S_RMWRD: begin
                    mem_addr = {{(32-AW){1'b0}}, addr_q[AW+1:2]};
                end
                S_STWR: begin
                    mem_addr = {{(32-AW){1'b0}}, addr_q[AW+1:2]};
                    mem_din  = wdata_q;
                    mem_we   = 1'b1;
                end
                S_RMWWR: begin
                    mem_addr = {{(32-AW){1'b0}}, addr_q[AW+1:2]};
                    mem_din  = merge_q;
                    mem_we   = 1'b1;
                end
                S_RESP: begin
                    resp_valid = 1'b1;
                    resp_rdata = rdata_q;
                    resp_err   = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store initiator between the CPU execute stage and the word-addressed, single-port data memory. Memory has combinational read, write on posedge when write-enable is high, 32-bit words, word index on its addr port.
- Accepts byte-addressed RV32I loads and stores of width B/H/W.
- Loads are aligned, then sign- or zero-extended.
- SB/SH are done as a read-modify-write, because the memory has no byte enables.
- Misaligned, out-of-range and illegal-funct3 requests return an error and never touch memory.

Parameters:
- DEPTH, 128, number of 32-bit words in the attached memory.
- AW, 7, word-index bits used (log2 DEPTH).

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3 (size and sign).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; low bytes used for SB/SH.
- resp_valid  output  1  response present.
- resp_ready  input  1  response consumed when resp_valid && resp_ready.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  request rejected.
- mem_addr  output  32  word index to memory, zero-extended from AW bits.
- mem_din  output  32  write data to memory.
- mem_we  output  1  memory write enable.
- mem_dout  input  32  combinational read data from memory.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- While rst is high and after reset:
  - FSM in IDLE.
  - req_ready=0 while rst is high; 1 in IDLE afterwards.
  - resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_din=0.
  - Memory contents are not affected by reset.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Error conditions (checked in IDLE at accept):
  - illegal funct3;
  - H access with addr[0]=1;
  - W access with addr[1:0]!=0;
  - addr[31:2] >= DEPTH.
  - On error: go to RESP with resp_err=1, resp_rdata=0. mem_we stays 0 for the whole transaction.
- FSM:
  - IDLE: req_ready=1. On accept, latch addr, funct3 and wdata, then go to:
    - RESP if error;
    - LOAD for a load;
    - STWR for SW;
    - RMWRD for SB/SH.
  - LOAD: mem_addr = addr[AW+1:2], mem_we=0.
    - Select byte addr[1:0] or halfword addr[1] from mem_dout.
    - Sign-extend for LB/LH, zero-extend for LBU/LHU.
    - Register the result into resp_rdata, then go to RESP.
  - STWR: mem_we=1, mem_din=wdata, then go to RESP.
  - RMWRD: mem_we=0. Register a merged word into mem_din, then go to RMWWR.
    - The merged word is mem_dout with the target byte/halfword replaced by wdata[7:0] or wdata[15:0] at lane addr[1:0].
  - RMWWR: mem_we=1 with the merged word, same mem_addr, then go to RESP.
  - RESP: resp_valid=1; resp_rdata and resp_err held stable.
    - On resp_ready go to IDLE; resp_valid drops the next cycle.
- mem_we is asserted only in STWR and RMWWR, for exactly one cycle. mem_addr holds the latched word index from LOAD through RMWWR.
- Latency, accept cycle N to first resp_valid cycle:
  - error: N+1;
  - load: N+2;
  - SW: N+2;
  - SB/SH: N+3.
- Throughput: one outstanding request. req_ready=0 in every state except IDLE. A new request is accepted no earlier than the cycle after the response handshake.
- Backpressure: with resp_ready low, RESP is held indefinitely and no memory access occurs.
- Reset mid-operation: rst in any state forces IDLE the same edge, and mem_we=0 in that cycle.
  - A reset during RMWRD or RMWWR produces no write, so the memory word is left at its old value.
  - A pending response is dropped.
- Byte lanes: lane k = bits [8k+7:8k]; addr[1:0]=k selects lane k. Halfword lane = bits [16h+15:16h] with h=addr[1].

Test Plan:
- Memory words 0..3 preloaded 0x2, 0x4, 0x8, 0x3. LW addr 0x8 -> resp_valid at N+2, resp_rdata=0x00000008, resp_err=0, mem_we never high.
- SB addr 0x5, wdata 0x123456AB -> one RMWRD cycle, then mem_we=1 for one cycle with mem_addr=1, mem_din=0x0000AB04. Response at N+3.
  - Then LB 0x5 -> 0xFFFFFFAB.
  - LBU 0x5 -> 0x000000AB.
  - LW 0x4 -> 0x0000AB04.
- SH addr 0xE, wdata 0x00008001 -> word3 becomes 0x80010003. LH 0xE -> 0xFFFF8001; LHU 0xE -> 0x00008001.
- Error cases, each giving resp_err=1 and resp_rdata=0 at N+1, with no mem_we and word contents unchanged:
  - LH 0x3;
  - SW 0x6;
  - LW 0x200 (word 128);
  - funct3=011 load;
  - store funct3=100.
- Hold resp_ready=0 for 3 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0, and a req_valid pulse is ignored. Release -> IDLE next cycle, and the next request is accepted.
- Assert rst for one cycle during RMWWR of SB 0x0 wdata 0xFF -> mem_we=0 that cycle, word0 still 0x2, resp_valid=0, and req_ready=1 the cycle after rst falls.
